// File: rtl/simd_shift_pkg.sv
// Shared encodings for the lane-aware SIMD shift unit: modes, lanes,
// FSM states, shift-amount masks and per-lane MSB/LSB bit patterns.
package simd_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        LANE_4    = 2'b00,
        LANE_8    = 2'b01,
        LANE_16   = 2'b10,
        LANE_FULL = 2'b11
    } lane_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Shift amounts are reduced to the lane width minus one.
    localparam logic [7:0] AMT_MASK_4  = 8'h03;
    localparam logic [7:0] AMT_MASK_8  = 8'h07;
    localparam logic [7:0] AMT_MASK_16 = 8'h0F;

    // Lane boundary patterns at the widest legal datapath;
    // consumers slice the low DATA_W bits.
    localparam logic [63:0] LANE4_MSB  = 64'h8888_8888_8888_8888;
    localparam logic [63:0] LANE4_LSB  = 64'h1111_1111_1111_1111;
    localparam logic [63:0] LANE8_MSB  = 64'h8080_8080_8080_8080;
    localparam logic [63:0] LANE8_LSB  = 64'h0101_0101_0101_0101;
    localparam logic [63:0] LANE16_MSB = 64'h8000_8000_8000_8000;
    localparam logic [63:0] LANE16_LSB = 64'h0001_0001_0001_0001;

endpackage

// File: rtl/simd_shift_step.sv
// One-position lane-aware shift (combinational). Ports: data, mode, lane
// in; shifted out. Rotate exists only with SIMD_SHIFT_ROTATE_EN defined.
module simd_shift_step
    import simd_shift_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic [1:0]        lane,
    output logic [DATA_W-1:0] shifted
);

    logic [DATA_W-1:0] msb;
    logic [DATA_W-1:0] lsb;
    logic [DATA_W-1:0] lsl;
    logic [DATA_W-1:0] lsr;
    logic [DATA_W-1:0] asr;

    always_comb begin
        msb = {1'b1, {(DATA_W-1){1'b0}}};
        lsb = {{(DATA_W-1){1'b0}}, 1'b1};
        unique case (lane)
            LANE_4: begin
                msb = LANE4_MSB[DATA_W-1:0];
                lsb = LANE4_LSB[DATA_W-1:0];
            end
            LANE_8: begin
                msb = LANE8_MSB[DATA_W-1:0];
                lsb = LANE8_LSB[DATA_W-1:0];
            end
            LANE_16: begin
                msb = LANE16_MSB[DATA_W-1:0];
                lsb = LANE16_LSB[DATA_W-1:0];
            end
            LANE_FULL: begin
                msb = {1'b1, {(DATA_W-1){1'b0}}};
                lsb = {{(DATA_W-1){1'b0}}, 1'b1};
            end
        endcase
    end

    // Whole-word shift, then clear the bits that crossed a lane edge.
    assign lsl = (data << 1) & ~lsb;
    assign lsr = (data >> 1) & ~msb;
    assign asr = lsr | (data & msb);

`ifdef SIMD_SHIFT_ROTATE_EN
    logic [DATA_W-1:0] wrap;
    logic [DATA_W-1:0] rol;

    // Each lane MSB drops down onto its own lane LSB.
    always_comb begin
        wrap = '0;
        unique case (lane)
            LANE_4:    wrap = (data & msb) >> 3;
            LANE_8:    wrap = (data & msb) >> 7;
            LANE_16:   wrap = (data & msb) >> 15;
            LANE_FULL: wrap = (data & msb) >> (DATA_W - 1);
        endcase
    end

    assign rol = lsl | wrap;

    always_comb begin
        shifted = lsr;
        unique case (mode)
            MODE_LSL: shifted = lsl;
            MODE_LSR: shifted = lsr;
            MODE_ASR: shifted = asr;
            MODE_ROL: shifted = rol;
        endcase
    end
`else
    always_comb begin
        shifted = lsr;
        unique case (mode)
            MODE_LSL:           shifted = lsl;
            MODE_LSR, MODE_ROL: shifted = lsr;
            MODE_ASR:           shifted = asr;
        endcase
    end
`endif

endmodule

// File: rtl/simd_shift_unit.sv
// Multi-cycle SIMD shifter: one lane-local bit position per cycle.
// Ports: clk, rst (sync high), in_valid/in_ready/in_data/in_amt/in_mode/
// in_lane, out_valid/out_ready/out_data, busy. Macro: SIMD_SHIFT_ROTATE_EN.
module simd_shift_unit
    import simd_shift_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        in_mode,
    input  logic [1:0]        in_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e            state;
    logic [AMT_W-1:0]  count;
    logic [DATA_W-1:0] work;
    logic [1:0]        mode_q;
    logic [1:0]        lane_q;
    logic [AMT_W-1:0]  amt_m;
    logic [DATA_W-1:0] step_out;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        amt_m = in_amt;
        unique case (in_lane)
            LANE_4:    amt_m = in_amt & AMT_MASK_4[AMT_W-1:0];
            LANE_8:    amt_m = in_amt & AMT_MASK_8[AMT_W-1:0];
            LANE_16:   amt_m = in_amt & AMT_MASK_16[AMT_W-1:0];
            LANE_FULL: amt_m = in_amt;
        endcase
    end

    simd_shift_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .data    (work),
        .mode    (mode_q),
        .lane    (lane_q),
        .shifted (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            work      <= '0;
            mode_q    <= 2'b00;
            lane_q    <= 2'b00;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work   <= in_data;
                        mode_q <= in_mode;
                        lane_q <= in_lane;
                        count  <= amt_m;
                        if (amt_m == '0) begin
                            state     <= DONE;
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work  <= step_out;
                    count <= count - AMT_W'(1);
                    // Result is published as the last step lands.
                    if (count == AMT_W'(1)) begin
                        state     <= DONE;
                        out_data  <= step_out;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_shift_unit.sv
// Scoreboard bench for simd_shift_unit at DATA_W=16: directed vectors,
// expected results queued at accept, checked by an independent monitor.
module tb_simd_shift_unit;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic [1:0]    in_mode = 2'b00;
    logic [1:0]    in_lane = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          busy;

    typedef struct {
        string         name;
        logic [DW-1:0] data;
        int            lat;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    simd_shift_unit #(.DATA_W(DW), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .in_lane   (in_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Monitor: each new out_valid is matched against the oldest entry.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (out_valid && !prev_valid) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: out_data=%h, none pending",
                         out_data);
            end else begin
                e   = q.pop_front();
                lat = cyc - e.acc + 1;
                if (out_data !== e.data || lat != e.lat) begin
                    fails++;
                    $display("FAIL %s: got %h lat %0d, want %h lat %0d",
                             e.name, out_data, lat, e.data, e.lat);
                end
            end
        end
        prev_valid = out_valid;
    end

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic send(input string name, input logic [1:0] mode,
                        input logic [1:0] lane, input logic [DW-1:0] data,
                        input logic [AW-1:0] amt, input logic [DW-1:0] want,
                        input int lat, input bit push, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_lane  = lane;
        in_data  = data;
        in_amt   = amt;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL %s_accept: in_ready stayed 0, want 1", name);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (push) begin
                e.name = name;
                e.data = want;
                e.lat  = lat;
                e.acc  = acc;
                q.push_back(e);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy=%0b pending=%0d, want idle",
                     busy, q.size());
        end
    endtask

    logic [DW-1:0] rot_a;
    logic [DW-1:0] rot_b;

    initial begin
        int acc_a;
        int acc_b;
        int hs;
        int n;

`ifdef SIMD_SHIFT_ROTATE_EN
        rot_a = 16'h1842;
        rot_b = 16'h183C;
`else
        rot_a = 16'h4210;
        rot_b = 16'h080C;
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", {15'd0, in_ready}, 16'd1);
        chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset_out_data", out_data, 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'd0);

        send("lsl_l4", 2'b00, 2'b00, 16'h1234, 4'd5, 16'h2468, 2, 1, acc_a);
        wait_idle();
        send("asr_l8", 2'b10, 2'b01, 16'h80F0, 4'd3, 16'hF0FE, 4, 1, acc_a);
        wait_idle();
        send("lsr_l16_amt0", 2'b01, 2'b10, 16'hABCD, 4'd0, 16'hABCD, 1, 1,
             acc_a);
        wait_idle();
        send("mode3_l4", 2'b11, 2'b00, 16'h8421, 4'd1, rot_a, 2, 1, acc_a);
        wait_idle();
        send("asr_full", 2'b10, 2'b11, 16'h8001, 4'd4, 16'hF800, 5, 1, acc_a);
        wait_idle();
        send("lsl_full15", 2'b00, 2'b11, 16'h0001, 4'd15, 16'h8000, 16, 1,
             acc_a);
        wait_idle();
        send("lsr_l8_mask", 2'b01, 2'b01, 16'hFF80, 4'd10, 16'h3F20, 3, 1,
             acc_a);
        wait_idle();
        send("mode3_l8", 2'b11, 2'b01, 16'h81C3, 4'd4, rot_b, 5, 1, acc_a);
        wait_idle();
        send("asr_l4", 2'b10, 2'b00, 16'h8F70, 4'd2, 16'hEF10, 3, 1, acc_a);
        wait_idle();
        send("lsr_l16_14", 2'b01, 2'b10, 16'h4000, 4'd14, 16'h0001, 15, 1,
             acc_a);
        wait_idle();

        // Back-pressure in DONE with a second request held on the input.
        out_ready = 1'b0;
        send("bp_first", 2'b00, 2'b01, 16'h0102, 4'd1, 16'h0204, 2, 1, acc_a);
        hs = -1;
        fork
            send("bp_second", 2'b00, 2'b11, 16'h0001, 4'd2, 16'h0004, 3, 1,
                 acc_b);
            begin
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_reach_done", {15'd0, out_valid}, 16'd1);
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_hold_data", out_data, 16'h0204);
                    chk("bp_hold_valid", {15'd0, out_valid}, 16'd1);
                    chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1 hs = cyc;
                chk("bp_valid_drop", {15'd0, out_valid}, 16'd0);
                chk("bp_idle_hold", out_data, 16'h0204);
            end
        join
        chk("bp_accept_next", 16'(acc_b - hs), 16'd1);
        @(negedge clk);
        chk("bp_shift_hold", out_data, 16'h0204);
        wait_idle();

        // Reset in the middle of a long shift must discard it.
        send("rst_mid", 2'b00, 2'b11, 16'h00FF, 4'd7, 16'h0000, 8, 0, acc_a);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_busy", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_mid_in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_mid_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_mid_data", out_data, 16'h0000);
        chk("rst_mid_busy0", {15'd0, busy}, 16'd0);
        repeat (12) begin
            @(negedge clk);
            chk("rst_no_stale", {15'd0, out_valid}, 16'd0);
        end
        send("post_rst", 2'b10, 2'b10, 16'hC000, 4'd1, 16'hE000, 2, 1, acc_a);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
